// File: rtl/lfsr_decrypter.sv
// LFSR message decrypter: recovers seed and tap pattern from the space-filled
// preamble, then writes the plaintext (leading spaces stripped) to data memory.
module lfsr_decrypter #(
  parameter int         ENC_BASE = 64,
  parameter int         OUT_BASE = 0,
  parameter int         MSG_LEN  = 41,
  parameter logic [7:0] PAD      = 8'h20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [7:0] mem_addr,
  output logic       mem_we,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic       halt,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_SEARCH,
    S_RESTART,
    S_SCAN,
    S_WRITE,
    S_FILL,
    S_DONE
  } state_t;

  // Sub-step inside a state: a read is PH_A (address out) then PH_D (data in);
  // WRITE cycles PH_W -> PH_A -> PH_D -> PH_W so a write never shares a read cycle.
  localparam logic [1:0] PH_A = 2'd0;
  localparam logic [1:0] PH_D = 2'd1;
  localparam logic [1:0] PH_W = 2'd2;

  localparam logic [7:0] ENC_A  = 8'(ENC_BASE);
  localparam logic [7:0] OUT_A  = 8'(OUT_BASE);
  localparam logic [7:0] LAST_J = 8'(MSG_LEN - 1);

  state_t     state, state_nx;
  logic [1:0] phase, phase_nx;
  logic [7:0] seed, seed_nx;
  logic [7:0] s, s_nx;
  logic [7:0] p, p_nx;
  logic [6:0] i, i_nx;
  logic [7:0] j, j_nx;
  logic [2:0] k, k_nx;
  logic [3:0] cnt, cnt_nx;
  logic       err_q, err_nx;
  logic [7:0] pv;
  logic [7:0] ptrn;

  function automatic logic [7:0] tap_of(input logic [2:0] idx);
    logic [7:0] t;
    case (idx)
      3'd0:    t = 8'he1;
      3'd1:    t = 8'hd4;
      3'd2:    t = 8'hc6;
      3'd3:    t = 8'hb8;
      3'd4:    t = 8'hb4;
      3'd5:    t = 8'hb2;
      3'd6:    t = 8'hfa;
      default: t = 8'hf3;
    endcase
    return t;
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] st, input logic [7:0] tp);
    return {st[6:0], ^(st & tp)};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      phase <= PH_A;
      seed  <= 8'h00;
      s     <= 8'h00;
      p     <= 8'h00;
      i     <= 7'd0;
      j     <= 8'd0;
      k     <= 3'd0;
      cnt   <= 4'd0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      phase <= phase_nx;
      seed  <= seed_nx;
      s     <= s_nx;
      p     <= p_nx;
      i     <= i_nx;
      j     <= j_nx;
      k     <= k_nx;
      cnt   <= cnt_nx;
      err_q <= err_nx;
    end
  end

  // s always holds the keystream byte for the ciphertext byte being fetched.
  assign pv   = mem_rdata ^ s;
  assign ptrn = tap_of(k);

  always_comb begin
    state_nx  = state;
    phase_nx  = phase;
    seed_nx   = seed;
    s_nx      = s;
    p_nx      = p;
    i_nx      = i;
    j_nx      = j;
    k_nx      = k;
    cnt_nx    = cnt;
    err_nx    = err_q;
    mem_addr  = 8'h00;
    mem_we    = 1'b0;
    mem_wdata = 8'h00;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_SEED;
          phase_nx = PH_A;
          err_nx   = 1'b0;
        end
      end

      S_SEED: begin
        if (phase == PH_A) begin
          mem_addr = ENC_A;
          phase_nx = PH_D;
        end else begin
          seed_nx  = mem_rdata ^ PAD;
          s_nx     = lfsr_step(mem_rdata ^ PAD, tap_of(3'd0));
          k_nx     = 3'd0;
          cnt_nx   = 4'd1;
          phase_nx = PH_A;
          state_nx = S_SEARCH;
        end
      end

      S_SEARCH: begin
        if (phase == PH_A) begin
          mem_addr = ENC_A + {4'b0000, cnt};
          phase_nx = PH_D;
        end else begin
          phase_nx = PH_A;
          if (pv == PAD) begin
            if (cnt == 4'd8) begin
              state_nx = S_RESTART;
            end else begin
              cnt_nx = cnt + 4'd1;
              s_nx   = lfsr_step(s, ptrn);
            end
          end else if (k == 3'd7) begin
            err_nx   = 1'b1;
            state_nx = S_DONE;
          end else begin
            // Abandon this candidate and replay the preamble with the next tap.
            k_nx   = k + 3'd1;
            cnt_nx = 4'd1;
            s_nx   = lfsr_step(seed, tap_of(k + 3'd1));
          end
        end
      end

      S_RESTART: begin
        s_nx     = seed;
        i_nx     = 7'd0;
        j_nx     = 8'd0;
        phase_nx = PH_A;
        state_nx = S_SCAN;
      end

      S_SCAN: begin
        if (phase == PH_A) begin
          mem_addr = ENC_A + {1'b0, i};
          phase_nx = PH_D;
        end else if (pv == PAD) begin
          if (i < 7'd63) begin
            s_nx     = lfsr_step(s, ptrn);
            i_nx     = i + 7'd1;
            phase_nx = PH_A;
          end else begin
            j_nx     = 8'd0;
            phase_nx = PH_A;
            state_nx = S_FILL;
          end
        end else begin
          p_nx     = pv;
          phase_nx = PH_W;
          state_nx = S_WRITE;
        end
      end

      S_WRITE: begin
        if (phase == PH_W) begin
          mem_we    = 1'b1;
          mem_addr  = OUT_A + j;
          mem_wdata = p;
          j_nx      = j + 8'd1;
          s_nx      = lfsr_step(s, ptrn);
          i_nx      = i + 7'd1;
          phase_nx  = PH_A;
          if (j == LAST_J) begin
            state_nx = S_DONE;
          end else if (i == 7'd63) begin
            state_nx = S_FILL;
          end
        end else if (phase == PH_A) begin
          mem_addr = ENC_A + {1'b0, i};
          phase_nx = PH_D;
        end else begin
          p_nx     = pv;
          phase_nx = PH_W;
        end
      end

      S_FILL: begin
        mem_we    = 1'b1;
        mem_addr  = OUT_A + j;
        mem_wdata = PAD;
        j_nx      = j + 8'd1;
        if (j == LAST_J) begin
          state_nx = S_DONE;
        end
      end

      S_DONE: begin
        if (start) begin
          state_nx = S_SEED;
          phase_nx = PH_A;
          err_nx   = 1'b0;
        end
      end

      default: begin
        state_nx = S_IDLE;
        phase_nx = PH_A;
      end
    endcase
  end

  assign halt = (state == S_DONE);
  assign err  = err_q;

endmodule

// File: tb/tb_lfsr_decrypter.sv
// Bench for lfsr_decrypter: encrypts known messages into a memory model,
// runs the decrypter and checks the plaintext written back.
module tb_lfsr_decrypter;

  localparam int         MSG_LEN = 41;
  localparam logic [7:0] PAD     = 8'h20;
  localparam logic [7:0] SENT    = 8'hee;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic       halt;
  logic       err;

  lfsr_decrypter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .halt      (halt),
    .err       (err)
  );

  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [7:0] ct [64];
  logic [7:0] om [256];
  logic       clr = 1'b0;
  int         wr_cnt = 0;
  int         bad_wr = 0;

  always @(posedge clk) begin
    if (clr) begin
      for (int a = 0; a < 256; a++) om[a] <= SENT;
    end else if (mem_we) begin
      om[mem_addr] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
      if (int'(mem_addr) >= MSG_LEN) bad_wr <= bad_wr + 1;
    end
    if (!mem_we)
      mem_rdata <= (mem_addr >= 8'd64 && mem_addr < 8'd128) ? ct[mem_addr[5:0]] : om[mem_addr];
  end

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] pt [64];
  string      msgs [6];

  typedef struct {
    logic [7:0] seed;
    logic [7:0] ptrn;
    int         pre;
    int         msg_id;
    bit         zero_ct;
    bit         exp_err;
    logic [7:0] exp_b0;
    logic [7:0] exp_b40;
    int         exp_wr;
  } vec_t;

  localparam int NV = 14;
  vec_t       vecs [NV];
  logic [7:0] taps [8];

  function automatic logic [7:0] enc_step(input logic [7:0] st, input logic [7:0] tp);
    return {st[6:0], ^(st & tp)};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Build ciphertext in the memory model and the expected plaintext queue.
  task automatic load(input logic [7:0] seed, input logic [7:0] ptrn, input int pre,
                      input string m, input bit zero);
    logic [7:0] st;
    int         f;
    exp_q.delete();
    for (int x = 0; x < 64; x++) pt[x] = PAD;
    for (int c = 0; c < m.len(); c++) pt[pre + c] = m[c];
    st = seed;
    for (int x = 0; x < 64; x++) begin
      ct[x] = zero ? 8'h00 : (pt[x] ^ st);
      st = enc_step(st, ptrn);
    end
    f = 64;
    for (int x = 63; x >= 0; x--) if (pt[x] != PAD) f = x;
    for (int jj = 0; jj < MSG_LEN; jj++) begin
      if (zero) exp_q.push_back(SENT);
      else exp_q.push_back((f + jj < 64) ? pt[f + jj] : PAD);
    end
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  // Pulse start, optionally pulse start again after glitch_at cycles, wait for halt.
  task automatic run_dec(input string tag, input int glitch_at, output int cyc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " first read addr"}, int'(mem_addr), 64);
    cyc = 0;
    while (!halt && cyc < 400) begin
      start = (cyc == glitch_at);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check({tag, " halt reached"}, int'(halt), 1);
  endtask

  task automatic sb_check(input string tag);
    int         bad;
    logic [7:0] e;
    logic [7:0] bad_act;
    logic [7:0] bad_exp;
    bad = -1;
    bad_act = 8'h00;
    bad_exp = 8'h00;
    for (int jj = 0; jj < MSG_LEN; jj++) begin
      e = exp_q.pop_front();
      if (om[jj] !== e && bad < 0) begin
        bad = jj;
        bad_act = om[jj];
        bad_exp = e;
      end
    end
    n_checks++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s plaintext: mem[%0d] got 0x%0h, expected 0x%0h", tag, bad, bad_act, bad_exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int w0;
    int b0;
    int n;
    logic [7:0] e9;
    string tag;

    msgs[0] = "Mr. Watson, come here. I want to see you.";
    msgs[1] = "Knowledge comes, but wisdom lingers.     ";
    msgs[2] = "   Ajok";
    msgs[3] = "Hello, world";
    msgs[4] = "Fill test";
    msgs[5] = "";
    taps = '{8'he1, 8'hd4, 8'hc6, 8'hb8, 8'hb4, 8'hb2, 8'hfa, 8'hf3};

    vecs[0]  = '{8'h5a, 8'hd4,  9, 0, 1'b0, 1'b0, 8'h4d, 8'h2e, 41};
    vecs[1]  = '{8'h3f, 8'hb4,  9, 1, 1'b0, 1'b0, 8'h4b, 8'h20, 41};
    vecs[2]  = '{8'h0c, 8'hfa, 10, 2, 1'b0, 1'b0, 8'h41, 8'h20, 41};
    for (int t = 0; t < 8; t++)
      vecs[3 + t] = '{8'h01, taps[t], 9, 3, 1'b0, 1'b0, 8'h48, 8'h20, 41};
    vecs[11] = '{8'h00, 8'h00,  0, 5, 1'b1, 1'b1, SENT,  SENT,  0};
    vecs[12] = '{8'h01, 8'he1, 30, 4, 1'b0, 1'b0, 8'h46, 8'h20, 41};
    vecs[13] = '{8'h01, 8'hc6,  9, 5, 1'b0, 1'b0, 8'h20, 8'h20, 41};

    // reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset halt", int'(halt), 0);
    check("reset err", int'(err), 0);
    check("reset mem_we", int'(mem_we), 0);
    check("reset mem_addr", int'(mem_addr), 0);
    check("reset mem_wdata", int'(mem_wdata), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle halt", int'(halt), 0);

    // table-driven runs
    for (int r = 0; r < NV; r++) begin
      tag = $sformatf("row%0d", r);
      load(vecs[r].seed, vecs[r].ptrn, vecs[r].pre, msgs[vecs[r].msg_id], vecs[r].zero_ct);
      w0 = wr_cnt;
      b0 = bad_wr;
      run_dec(tag, -1, cyc);
      check({tag, " err"}, int'(err), int'(vecs[r].exp_err));
      check({tag, " cycles<=310"}, int'(cyc <= 310), 1);
      check({tag, " write count"}, wr_cnt - w0, vecs[r].exp_wr);
      check({tag, " out-of-range writes"}, bad_wr - b0, 0);
      check({tag, " mem[0]"}, int'(om[0]), int'(vecs[r].exp_b0));
      check({tag, " mem[40]"}, int'(om[40]), int'(vecs[r].exp_b40));
      sb_check(tag);
      repeat (3) @(posedge clk);
      #1;
      check({tag, " halt held"}, int'(halt), 1);
    end

    // start pulse during SEARCH is ignored: f3 run keeps its undisturbed length
    load(8'h01, 8'hf3, 9, msgs[3], 1'b0);
    run_dec("glitch", 10, cyc);
    check("glitch cycle count", cyc, 176);
    check("glitch err", int'(err), 0);
    sb_check("glitch");

    // asynchronous reset during the write of byte 10, then full re-run
    load(8'h5a, 8'hd4, 9, msgs[0], 1'b0);
    e9 = exp_q[9];
    w0 = wr_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(mem_we && mem_addr == 8'd10) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst: reached write j=10", int'(mem_we && mem_addr == 8'd10), 1);
    rst_n = 1'b0;
    #1;
    check("rst: mem_we", int'(mem_we), 0);
    check("rst: mem_addr", int'(mem_addr), 0);
    check("rst: mem_wdata", int'(mem_wdata), 0);
    check("rst: halt", int'(halt), 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst: writes before abort", wr_cnt - w0, 10);
    check("rst: mem[9] kept", int'(om[9]), int'(e9));
    check("rst: mem[10] untouched", int'(om[10]), int'(SENT));
    rst_n = 1'b1;
    @(posedge clk); #1;
    w0 = wr_cnt;
    run_dec("rerun", -1, cyc);
    check("rerun err", int'(err), 0);
    check("rerun write count", wr_cnt - w0, 41);
    sb_check("rerun");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_decrypter.md
# lfsr_decrypter

Hardware decryption engine, the receive-side counterpart of the LFSR message encryptor. It reads a 64-byte ciphertext from data memory and recovers the LFSR starting state and tap pattern from the known space-filled preamble. It then writes the recovered plaintext message, with leading spaces stripped, back into data memory. It shares the data-memory port with the core and reports completion through `halt`.

## Interface
- `ENC_BASE`, 64: data-memory address of ciphertext byte 0 (64 bytes, ENC_BASE..ENC_BASE+63).
- `OUT_BASE`, 0: data-memory address of plaintext byte 0.
- `MSG_LEN`, 41: plaintext bytes written.
- `PAD`, 8'h20: preamble/pad character (ASCII space).
- `clk`  in  1  sole clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin decryption; sampled on rising edge while in IDLE or DONE.
- `mem_addr`  out  8  data-memory address.
- `mem_we`  out  1  write enable for `mem_wdata` at `mem_addr`.
- `mem_wdata`  out  8  write data.
- `mem_rdata`  in  8  read data; valid the cycle after `mem_addr` is presented with `mem_we`=0.
- `halt`  out  1  done flag; high in DONE.
- `err`  out  1  no tap pattern matched the preamble; valid while `halt`=1.

## Operation
- Tap table, index 0..7: e1, d4, c6, b8, b4, b2, fa, f3.
- LFSR step: next = {s[6:0], ^(s & ptrn)}.
- Cipher model: c[i] = p[i] ^ s[i], with s[0] = seed.
- Preamble p[0..8] = PAD is guaranteed (preamble length ≥ 9).
- State IDLE: outputs quiescent; `start` moves to SEED.
- State SEED: read c[0]; seed = c[0] ^ PAD.
- State SEARCH: for k = 0..7 in order:
  - set s = seed; for i = 1..8, step s with tap[k], read c[i], compare c[i] ^ s with PAD.
  - On the first mismatch, abandon k and go to k+1.
  - All 8 bytes matching selects tap[k] and goes to RESTART.
  - k = 7 failing sets `err`=1 and goes to DONE; no writes are performed.
- State RESTART: s = seed, i = 0, j = 0.
- State SCAN: read c[i], p = c[i] ^ s.
  - If p == PAD and i < 63: step s, i++, and stay in SCAN.
  - Otherwise go to WRITE with the current p.
  - i == 63 with p == PAD goes to FILL with j = 0.
- State WRITE: write p to OUT_BASE+j, j++, step s, i++.
  - If j == MSG_LEN: go to DONE.
  - Else if i == 64: go to FILL.
  - Otherwise read c[i], form p, and repeat WRITE.
  - Leading spaces are stripped; interior and trailing spaces are copied verbatim.
- State FILL: write PAD to OUT_BASE+j, j++ until j == MSG_LEN, then go to DONE.
- State DONE: `halt`=1 and `err` held.
  - `start` returns to SEED and clears `halt` and `err`.
  - DONE never re-enters IDLE without reset.
- `start` asserted in any other state is ignored.
- Address arithmetic is 8-bit. ENC_BASE+63 and OUT_BASE+MSG_LEN-1 must be ≤ 255; there is no wrap-around.
- The block never writes ciphertext addresses.

## Timing
- Reset (async, immediate): state=IDLE, `halt`=0, `err`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, internal seed/s/i/j/k=0.
- Reset asserted mid-operation aborts with no further writes. Partial plaintext already written stays in memory.
- Every read costs 2 cycles: address in cycle t, `mem_rdata` registered at the end of t+1.
- `mem_we` pulses exactly 1 cycle per written byte, with `mem_addr`/`mem_wdata` stable in that cycle.
- Writes never overlap a read cycle.
- `start` edge to first memory read: 1 cycle.
- SEARCH worst case: 8 patterns × 8 reads × 2 cycles = 128 cycles.
- Whole run is bounded by 2 + 128 + 64×2 + MSG_LEN×1 + 2 cycles (≤ 310 for defaults).
- `halt` rises on the cycle after the last write (or after the failing compare), and stays high until reset or `start`.

## Test plan
- Ptrn d4, seed 5a, preamble 9, "Mr. Watson, come here. I want to see you." encrypted to 64 bytes (c[0]=7a) -> mem[0]=4D 'M', mem[40]=2E '.', mem[0..40] equals the string; `err`=0, `halt`=1.
- Ptrn b4, seed 3f, preamble 9, "Knowledge comes, but wisdom lingers.     " -> trailing 5 spaces reproduced at mem[36..40]; no write above address 40.
- Ptrn fa, seed 0c, preamble 10, "   Ajok" plus spaces -> mem[0..3]="Ajok", mem[4..40]=20 (leading spaces stripped; FILL pads).
- Each of the 8 patterns with seed 01 and an identical message -> correct plaintext in every case. Pattern f3 exercises the full 7-candidate rejection path before the match.
- Ciphertext of all zero bytes -> seed 20, no pattern matches -> `err`=1, `halt`=1, zero `mem_we` pulses.
- Assert `rst_n`=0 during WRITE at j=10 -> outputs reset immediately. After release, `start` re-runs the decryption to the correct full result. A `start` pulse mid-SEARCH has no effect.
